// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the 8-bit CPU front end.
//                ADDR_W   - program ROM word address width (PC width)
//                DATA_W   - instruction word width
//                RESET_PC - PC value after reset
//                instr_t / pc_t / fetch_entry_t - fetch datapath types
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 16;
    localparam int RESET_PC = 0;

    typedef logic [DATA_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0] pc_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        instr_t word;
        pc_t    pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buf
//  Description : Small in-order FIFO of fetch_entry_t holding fetched words
//                until decode accepts them. Entry 0 is always the head, so
//                the output is a plain register read.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                flush       - drop all entries (wins over push/pop)
//                push, din   - append an entry
//                pop         - remove the head entry
//                head        - current head entry
//                occ         - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     din,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [OCC_W-1:0] occ
);

    fetch_entry_t     r_mem     [DEPTH];
    fetch_entry_t     w_mem_nxt [DEPTH];
    logic [OCC_W-1:0] r_occ;
    int               w_wr_idx;

    // A pop shifts everything one slot toward the head; the pushed entry
    // then lands in the first free slot after that shift.
    always_comb begin
        w_wr_idx = int'(r_occ) - (pop ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_nxt[i] = r_mem[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_mem_nxt[i] = r_mem[i + 1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_idx == i) begin
                    w_mem_nxt[i] = din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(push) - OCC_W'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
        end
    end

    assign head = r_mem[0];
    assign occ  = r_occ;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage. Owns the PC, issues reads to the
//                synchronous program ROM (1-cycle latency), buffers returned
//                words and hands them to decode over valid/ready. A redirect
//                loads a new PC and flushes buffered and in-flight words.
//  Build macro : FETCH_SKID_EN - 2-entry output buffer (1 instr/cycle);
//                undefined     - 1-entry buffer (1 instr every 2 cycles).
//  Ports       : clk, reset                  - clock, sync active-high reset
//                redirect_valid/redirect_pc  - jump/branch target
//                rom_ad/rom_ce/rom_oce/rom_reset, rom_dout - program ROM
//                instr_valid/instr_ready/instr/instr_pc    - to decode
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    import cpu_pkg::*;

`ifdef FETCH_SKID_EN
    localparam int c_DEPTH = 2;
`else
    localparam int c_DEPTH = 1;
`endif
    localparam int c_OCC_W = $clog2(c_DEPTH + 1);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [ADDR_W-1:0]  r_rom_ad;
    logic               r_inflight;

    logic               w_pop;
    logic               w_push;
    logic               w_credit_ok;
    logic               w_issue;
    logic [c_OCC_W-1:0] w_occ;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    assign w_pop = instr_valid && instr_ready;

    // A read may only be issued if its word is guaranteed a buffer slot when
    // it returns: buffered + in-flight + this one must fit, counting the slot
    // freed by a handshake this cycle.
    assign w_credit_ok = (int'(w_occ) + (r_inflight ? 1 : 0) + 1)
                         <= (c_DEPTH + (w_pop ? 1 : 0));
    assign w_issue     = !reset && !redirect_valid && w_credit_ok;

    // Returning data is dropped in the redirect cycle: it belongs to the
    // old instruction stream.
    assign w_push = r_inflight && !redirect_valid;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.word = rom_dout;
        w_push_entry.pc   = r_inflight_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= ADDR_W'(RESET_PC);
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rom_ad      <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + ADDR_W'(1);
                r_rom_ad      <= r_pc;
            end
        end
    end

    fetch_buf #(
        .DEPTH (c_DEPTH)
    ) u_fetch_buf (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (w_push),
        .din   (w_push_entry),
        .pop   (w_pop),
        .head  (w_head),
        .occ   (w_occ)
    );

    // rom_ad follows the PC on an issue and otherwise holds the last address.
    assign rom_ce      = w_issue;
    assign rom_ad      = w_issue ? r_pc : r_rom_ad;
    assign rom_oce     = 1'b1;
    assign rom_reset   = reset;

    assign instr_valid = (w_occ != '0);
    assign instr       = w_head.word;
    assign instr_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A behavioural ROM feeds
//                the DUT; a stream-level reference model (expected next
//                delivered PC, issue PC and outstanding-word count) checks
//                every cycle, with directed scenarios followed by random
//                ready/redirect/reset traffic. Honours FETCH_SKID_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

`ifdef FETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [10:0] redirect_pc;
    logic [10:0] rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [15:0] rom_dout;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [10:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_ad         (rom_ad),
        .rom_ce         (rom_ce),
        .rom_oce        (rom_oce),
        .rom_reset      (rom_reset),
        .rom_dout       (rom_dout),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Behavioural synchronous program ROM.
    logic [15:0] rom [2048];
    always @(posedge clk) begin
        if (rom_reset)   rom_dout <= 16'h0000;
        else if (rom_ce) rom_dout <= rom[rom_ad];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [10:0] exp_pc, issue_pc, last_ad;
    int          owed, age, rel, reset_run, n_acc;
    logic        stall_prev, saw_pc1, should_issue;
    logic [15:0] hold_w;
    logic [10:0] hold_p;
    logic        hv  [64];
    logic        hce [64];
    logic [15:0] hi  [64];
    logic [10:0] hp  [64];
    logic [10:0] ha  [64];
    logic [10:0] acc_pc [$];
    logic [15:0] acc_w  [$];

    // Inputs are already driven; sample, update the model, advance one clock.
    task automatic cycle();
        #1;
        if (reset) begin
            if (reset_run >= 1) begin
                check("rst_valid", instr_valid, 0);
                check("rst_instr", instr, 0);
                check("rst_instr_pc", instr_pc, 0);
                check("rst_rom_ce", rom_ce, 0);
                check("rst_rom_ad", rom_ad, 0);
                check("rst_rom_oce", rom_oce, 1);
                check("rst_rom_reset", rom_reset, 1);
            end
            reset_run++;
            exp_pc = 0; issue_pc = 0; last_ad = 0; owed = 0;
            age = 1; rel = 0; stall_prev = 1'b0;
        end else begin
            reset_run = 0;
            if (age == 1 || age == 2) check("gap_valid", instr_valid, 0);
            if (stall_prev) begin
                check("hold_valid", instr_valid, 1);
                check("hold_instr", instr, hold_w);
                check("hold_instr_pc", instr_pc, hold_p);
            end
            if (rel < 64) begin
                hv[rel] = instr_valid; hi[rel] = instr; hp[rel] = instr_pc;
                hce[rel] = rom_ce; ha[rel] = rom_ad;
            end
            rel++;
            if (instr_valid && instr_ready) begin
                check("deliv_pc", instr_pc, exp_pc);
                check("deliv_word", instr, rom[exp_pc]);
                if (instr_pc == 11'd1) saw_pc1 = 1'b1;
                acc_pc.push_back(instr_pc);
                acc_w.push_back(instr);
                exp_pc = exp_pc + 11'd1;
                owed--;
                n_acc++;
            end
            if (redirect_valid) begin
                check("redir_rom_ce", rom_ce, 0);
                check("redir_rom_ad", rom_ad, last_ad);
                exp_pc = redirect_pc; issue_pc = redirect_pc; owed = 0; age = 1;
            end else begin
                should_issue = (owed + 1 <= DEPTH);
                check("issue_rule", rom_ce, should_issue);
                if (rom_ce) begin
                    check("issue_ad", rom_ad, issue_pc);
                    last_ad  = rom_ad;
                    issue_pc = issue_pc + 11'd1;
                    owed++;
                end else begin
                    check("idle_ad", rom_ad, last_ad);
                end
                if (age < 99) age++;
            end
            stall_prev = instr_valid && !instr_ready && !redirect_valid;
            hold_w = instr;
            hold_p = instr_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [15:0] w4 [4];
        int          step, issues, n0, c_idx, waited;
        logic        found;

        w4[0] = 16'h00A1; w4[1] = 16'h0078; w4[2] = 16'h0066; w4[3] = 16'h0091;
        for (int a = 0; a < 2048; a++) rom[a] = 16'((a * 40503) ^ 16'h5A5A);
        for (int a = 0; a < 4; a++) rom[a] = w4[a];

        exp_pc = 0; issue_pc = 0; last_ad = 0; owed = 0; age = 99; rel = 0;
        reset_run = 0; n_acc = 0; stall_prev = 1'b0; saw_pc1 = 1'b0;
        hold_w = 0; hold_p = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 0; instr_ready = 1'b0;
        step = (DEPTH == 2) ? 1 : 2;

        // Reset values, then streaming with decode always ready.
        repeat (3) cycle();
        reset = 1'b0; instr_ready = 1'b1;
        repeat (12) cycle();
        check("stream_v0", hv[0], 0);
        check("stream_v1", hv[1], 0);
        check("stream_first_issue", hce[0], 1);
        check("stream_first_ad", ha[0], 0);
        for (int k = 0; k < 4; k++) begin
            check("stream_valid", hv[2 + k*step], 1);
            check("stream_word", hi[2 + k*step], w4[k]);
            check("stream_pc", hp[2 + k*step], k);
        end
        if (step == 2)
            for (int k = 0; k < 3; k++) check("stream_gap", hv[3 + 2*k], 0);

        // Stall decode for 5 cycles after the first valid word.
        do_reset();
        repeat (7) cycle();
        issues = 0;
        for (int k = 0; k < 7; k++) issues += hce[k] ? 1 : 0;
        check("stall_issues", issues, DEPTH);
        check("stall_ce_low", hce[6], 0);
        check("stall_instr_first", hi[2], 16'h00A1);
        check("stall_valid_last", hv[6], 1);
        check("stall_instr_last", hi[6], 16'h00A1);
        acc_pc.delete(); acc_w.delete();
        instr_ready = 1'b1;
        repeat (14) cycle();
        check("stall_resume_cnt", acc_pc.size() >= 4, 1);
        if (acc_pc.size() >= 4)
            for (int k = 0; k < 4; k++) check("stall_resume_pc", acc_pc[k], k);

        // Redirect to pc2 while pc1's read is in flight.
        do_reset();
        instr_ready = 1'b1; saw_pc1 = 1'b0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (hce[rel-1] && ha[rel-1] == 11'd1) found = 1'b1;
        end
        check("redir_pc1_issued", found, 1);
        c_idx = rel;
        redirect_valid = 1'b1; redirect_pc = 11'd2;
        cycle();
        redirect_valid = 1'b0;
        repeat (5) cycle();
        check("redir_c1_valid", hv[c_idx+1], 0);
        check("redir_c2_valid", hv[c_idx+2], 0);
        check("redir_c3_valid", hv[c_idx+3], 1);
        check("redir_c3_word", hi[c_idx+3], 16'h0066);
        check("redir_c3_pc", hp[c_idx+3], 2);
        check("redir_pc1_killed", saw_pc1, 0);

        // Redirect to the last ROM word: delivery must wrap to pc0.
        acc_pc.delete(); acc_w.delete();
        redirect_valid = 1'b1; redirect_pc = 11'd2047;
        cycle();
        redirect_valid = 1'b0;
        waited = 0;
        while (acc_pc.size() < 2 && waited < 20) begin
            cycle();
            waited++;
        end
        check("wrap_cnt", acc_pc.size() >= 2, 1);
        if (acc_pc.size() >= 2) begin
            check("wrap_pc_last", acc_pc[0], 2047);
            check("wrap_word_last", acc_w[0], rom[2047]);
            check("wrap_pc_zero", acc_pc[1], 0);
            check("wrap_word_zero", acc_w[1], 16'h00A1);
        end

        // Reset mid-stream with a full buffer.
        do_reset();
        instr_ready = 1'b1;
        repeat (4) cycle();
        instr_ready = 1'b0;
        cycle();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0; instr_ready = 1'b1;
        repeat (5) cycle();
        check("rst_mid_v0", hv[0], 0);
        check("rst_mid_v1", hv[1], 0);
        check("rst_mid_valid", hv[2], 1);
        check("rst_mid_word", hi[2], 16'h00A1);
        check("rst_mid_pc", hp[2], 0);

        // Random ready / redirect / reset traffic.
        n0 = n_acc;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 399) == 0);
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = !reset && ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 11'd2047;
                1:       redirect_pc = 11'd2046;
                2:       redirect_pc = 11'($urandom_range(0, 3));
                default: redirect_pc = 11'($urandom_range(0, 2047));
            endcase
            cycle();
        end
        reset = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
        repeat (4) cycle();
        check("random_progress", (n_acc - n0) > 300, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
